// File: rtl/fp_mul_seq.sv
// fp_mul_seq: sequential shift-add IEEE-754-style multiplier with start/done/serv handshake.
// Build option: define FP_MUL_RNE_EN for round-to-nearest-even; otherwise results truncate.
module fp_mul_seq #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                   clk,
   input  logic                   n_rst,
   input  logic                   mul_start,
   input  logic                   mul_serv,
   input  logic [EXP_W+MAN_W:0]   op1,
   input  logic [EXP_W+MAN_W:0]   op2,
   output logic [EXP_W+MAN_W:0]   mul_result,
   output logic                   mul_done,
   output logic                   mul_busy,
   output logic                   mul_ovf,
   output logic                   mul_unf
);
   localparam int W    = 1 + EXP_W + MAN_W;
   localparam int M    = MAN_W + 1;
   localparam int AW   = 2 * M;
   localparam int EW   = EXP_W + 2;
   localparam int CW   = $clog2(M);
   localparam int BIAS = 2 ** (EXP_W - 1) - 1;

   typedef enum logic [1:0] {IDLE, MULT, NORM, DONE} state_t;

   state_t              state;
   logic [W-1:0]        a, b;
   logic [AW-1:0]       acc;
   logic [CW-1:0]       cnt;
   logic [M-1:0]        m1, m2;
   logic                hi, zin, ovf_n, unf_n;
   logic [MAN_W-1:0]    frac_t, frac_f;
   logic signed [EW-1:0] e_raw, e_fin;
   logic [W-1:0]        res_n;

   assign m1 = (a[W-2:MAN_W] == '0) ? '0 : {1'b1, a[MAN_W-1:0]};
   assign m2 = (b[W-2:MAN_W] == '0) ? '0 : {1'b1, b[MAN_W-1:0]};

   // Normalise, round and classify the accumulated product for the NORM cycle.
   always_comb begin
      hi     = acc[AW-1];
      zin    = (a[W-2:MAN_W] == '0) || (b[W-2:MAN_W] == '0);
      e_raw  = $signed(EW'(a[W-2:MAN_W])) + $signed(EW'(b[W-2:MAN_W]))
               - $signed(EW'(BIAS)) + $signed(EW'(hi));
      frac_t = hi ? acc[AW-2:M] : acc[AW-3:M-1];
`ifdef FP_MUL_RNE_EN
      begin
         logic guard, sticky, rup, cy;
         guard  = hi ? acc[M-1] : acc[M-2];
         sticky = hi ? |acc[M-2:0] : |acc[M-3:0];
         rup    = guard & (sticky | frac_t[0]);
         {cy, frac_f} = {1'b0, frac_t} + (MAN_W+1)'(rup);
         e_fin  = e_raw + $signed(EW'(cy));
      end
`else
      frac_f = frac_t;
      e_fin  = e_raw;
`endif
      ovf_n  = int'(e_fin) >= 2 ** EXP_W - 1;
      unf_n  = int'(e_fin) <= 0;
      res_n  = zin   ? {a[W-1] ^ b[W-1], {(W-1){1'b0}}} :
               ovf_n ? {a[W-1] ^ b[W-1], {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
               unf_n ? {a[W-1] ^ b[W-1], {(W-1){1'b0}}} :
                       {a[W-1] ^ b[W-1], e_fin[EXP_W-1:0], frac_f};
   end

   // Control FSM with the shift-add datapath and registered handshake outputs.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state      <= IDLE;
         a          <= '0;
         b          <= '0;
         acc        <= '0;
         cnt        <= '0;
         mul_result <= '0;
         mul_done   <= 1'b0;
         mul_busy   <= 1'b0;
         mul_ovf    <= 1'b0;
         mul_unf    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (mul_start) begin
               a        <= op1;
               b        <= op2;
               acc      <= '0;
               cnt      <= '0;
               mul_busy <= 1'b1;
               state    <= MULT;
            end
            MULT: begin
               if (m2[cnt]) acc <= acc + (AW'(m1) << cnt);
               cnt <= cnt + 1'b1;
               if (cnt == CW'(MAN_W)) state <= NORM;
            end
            NORM: begin
               mul_result <= res_n;
               mul_ovf    <= !zin && ovf_n;
               mul_unf    <= !zin && !ovf_n && unf_n;
               mul_done   <= 1'b1;
               mul_busy   <= 1'b0;
               state      <= DONE;
            end
            DONE: if (mul_serv) begin
               mul_done <= 1'b0;
               mul_ovf  <= 1'b0;
               mul_unf  <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
